// File: rtl/nport_ram_pkg.sv
// Shared types and helpers for the interleaved N-port RAM controller.
// Lane rotators work on a fixed maximum-width vector; callers size-cast in and out.
package nport_ram_pkg;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} ctrl_state_t;

  localparam int unsigned MAX_LANES = 16;
  localparam int unsigned MAX_DW    = 64;
  localparam int unsigned MAX_VEC   = MAX_LANES * MAX_DW;
  localparam int unsigned VEC_IDX_W = $clog2(MAX_VEC);

  typedef logic [MAX_VEC-1:0] lane_vec_t;

  function automatic int unsigned bank_bits(input int unsigned lanes);
    return $clog2(lanes);
  endfunction

  function automatic int unsigned row_bits(input int unsigned aw, input int unsigned lanes);
    return aw - $clog2(lanes);
  endfunction

  // Output lane j takes input lane (j - sh) mod lanes; bits above lanes*dw are zero.
  function automatic lane_vec_t rotl_lanes(input lane_vec_t v, input int unsigned lanes,
                                           input int unsigned dw, input int unsigned sh);
    lane_vec_t r;
    logic [VEC_IDX_W-1:0] src;
    r = '0;
    for (int unsigned b = 0; b < MAX_VEC; b++) begin
      if (b < lanes * dw) begin
        src = VEC_IDX_W'((((b / dw) + lanes - (sh & (lanes - 1))) & (lanes - 1)) * dw + (b % dw));
        r[VEC_IDX_W'(b)] = v[src];
      end
    end
    return r;
  endfunction

  // Output lane j takes input lane (j + sh) mod lanes.
  function automatic lane_vec_t rotr_lanes(input lane_vec_t v, input int unsigned lanes,
                                           input int unsigned dw, input int unsigned sh);
    lane_vec_t r;
    logic [VEC_IDX_W-1:0] src;
    r = '0;
    for (int unsigned b = 0; b < MAX_VEC; b++) begin
      if (b < lanes * dw) begin
        src = VEC_IDX_W'((((b / dw) + (sh & (lanes - 1))) & (lanes - 1)) * dw + (b % dw));
        r[VEC_IDX_W'(b)] = v[src];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nport_ram_bank.sv
// Single-port RAM bank: synchronous write, one-cycle registered read.
// The array itself is not reset; only the read register is.
module nport_ram_bank
  import nport_ram_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          en,
  input  logic          we,
  input  logic [RW-1:0] row,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**RW];

  always_ff @(posedge CLK) begin
    if (en && we) begin
      mem[row] <= wdata;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[row];
    end
  end

endmodule

// File: rtl/nport_ram_ctrl.sv
// LANES word-interleaved banks serving single words or unaligned LANES-wide vectors,
// with request/response handshakes and a post-reset zeroing sequencer.
module nport_ram_ctrl
  import nport_ram_pkg::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 16,
  parameter int unsigned LANES      = 4,
  parameter bit          CLEAR_INIT = 1'b1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic                req_vec,
  input  logic [AW-1:0]       req_addr,
  input  logic [LANES-1:0]    req_wmask,
  input  logic [LANES*DW-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [LANES*DW-1:0] resp_rdata,
  output logic                init_done,
  output logic                fsm_state
);

  localparam int unsigned BB = bank_bits(LANES);
  localparam int unsigned RB = row_bits(AW, LANES);
  localparam int unsigned VW = LANES * DW;

  ctrl_state_t state, state_nxt;
  logic [RB-1:0] clr_row, clr_row_nxt;

  logic                     fire, rd_fire;
  logic [BB-1:0]            shift;
  logic [RB-1:0]            base_row;
  logic [LANES-1:0]         lane_en;
  logic [VW-1:0]            wdata_rot;
  logic [LANES-1:0]         bank_en, bank_we;
  logic [LANES-1:0][RB-1:0] bank_row;
  logic [VW-1:0]            bank_wdata, bank_rdata;
  logic [VW-1:0]            rdata_rot, rdata_fmt, hold;
  logic                     resp_valid_q, fresh, resp_vec;
  logic [BB-1:0]            resp_shift;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Requests fire only in RUN while the response register is empty or draining;
  // a response is presented until resp_ready is sampled high alongside resp_valid.
  assign req_ready = (state == RUN) && (!resp_valid_q || resp_ready);
  assign fire      = req_valid && req_ready;
  assign rd_fire   = fire && !req_wen;
  assign shift     = req_addr[BB-1:0];
  assign base_row  = req_addr[AW-1:BB];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= CLEAR_INIT ? CLEAR : RUN;
      clr_row <= '0;
    end else begin
      state   <= state_nxt;
      clr_row <= clr_row_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_row_nxt = clr_row;
    case (state)
      CLEAR: begin
        clr_row_nxt = clr_row + 1'b1;
        if (&clr_row) begin
          state_nxt = RUN;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign init_done = (state == RUN);
  assign fsm_state = state;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_en[i] = req_vec ? req_wmask[i] : (i == 0);
    end
  end

  assign wdata_rot = VW'(rotl_lanes(MAX_VEC'(req_wdata), LANES, DW, 32'(shift)));

  // Banks below the start bank hold words that carried into the next row.
  always_comb begin
    for (int b = 0; b < LANES; b++) begin
      bank_en[b]             = 1'b0;
      bank_we[b]             = 1'b0;
      bank_row[b]            = base_row + RB'(BB'(b) < shift);
      bank_wdata[b*DW +: DW] = wdata_rot[b*DW +: DW];
      if (state == CLEAR) begin
        bank_en[b]             = 1'b1;
        bank_we[b]             = 1'b1;
        bank_row[b]            = clr_row;
        bank_wdata[b*DW +: DW] = '0;
      end else if (fire) begin
        bank_we[b] = req_wen;
        bank_en[b] = req_wen ? lane_en[BB'(b) - shift] : 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bank
    nport_ram_bank #(
      .DW (DW),
      .RW (RB)
    ) u_bank (
      .CLK   (CLK),
      .nRST  (nRST),
      .en    (bank_en[g]),
      .we    (bank_we[g]),
      .row   (bank_row[g]),
      .wdata (bank_wdata[g*DW +: DW]),
      .rdata (bank_rdata[g*DW +: DW])
    );
  end

  assign rdata_rot = VW'(rotr_lanes(MAX_VEC'(bank_rdata), LANES, DW, 32'(resp_shift)));

  always_comb begin
    rdata_fmt = rdata_rot;
    if (!resp_vec) begin
      rdata_fmt[VW-1:DW] = '0;
    end
  end

  // Bank outputs drive the response directly in the first cycle, then the held copy.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      resp_valid_q <= 1'b0;
      fresh        <= 1'b0;
      resp_vec     <= 1'b0;
      resp_shift   <= '0;
      hold         <= '0;
    end else begin
      fresh <= rd_fire;
      if (rd_fire) begin
        resp_vec   <= req_vec;
        resp_shift <= shift;
      end
      if (rd_fire) begin
        resp_valid_q <= 1'b1;
      end else if (resp_ready) begin
        resp_valid_q <= 1'b0;
      end
      if (fresh) begin
        hold <= rdata_fmt;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = fresh ? rdata_fmt : hold;

endmodule
